win_scan_accumulator: RTL and testbench

- Sequential, parametrised successor to the 12-case combinational win summariser.
- Accepts a stream of packed check-answer words, one per row, column or diagonal, over a valid/ready handshake.
- Reduces each word to a per-word colour result and accumulates it across a whole board scan of N_WORDS words.
- Reports the winning colour and the index of the first winning word to the game-control FSM, with a one-cycle done pulse.

---
 rtl/win_scan_accumulator.sv | 128 ++++++++++++
 tb/tb_win_scan_accumulator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/win_scan_accumulator.sv
// Streams packed check-answer words for one board scan and reports the winning colour and the first winning word.
// Optional WIN_TIE_DETECT_EN: a scan that sees both colours reports winner = 11 instead of giving colour A priority.
module win_scan_accumulator #(
    parameter int N_CASES = 12,
    parameter int N_WORDS = 60,
    parameter int IDX_W   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*N_CASES-1:0] check_ans,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           winner,
    output logic [IDX_W-1:0]     win_index
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic             saw_a;
    logic             saw_b;
    logic             hit;

    logic any_a;
    logic any_b;
    logic accept;
    logic last_word;
    logic saw_a_next;
    logic saw_b_next;
    logic [1:0] winner_next;

    // Fields 00 and 11 carry no win and are ignored.
    always_comb begin
        any_a = 1'b0;
        any_b = 1'b0;
        for (int i = 0; i < N_CASES; i++) begin
            if (check_ans[2*i +: 2] == 2'b01) any_a = 1'b1;
            if (check_ans[2*i +: 2] == 2'b10) any_b = 1'b1;
        end
    end

    assign accept     = in_valid && in_ready;
    assign last_word  = (cnt == IDX_W'(N_WORDS - 1));
    assign saw_a_next = saw_a | any_a;
    assign saw_b_next = saw_b | any_b;

    always_comb begin
        winner_next = 2'b00;
`ifdef WIN_TIE_DETECT_EN
        if (saw_a_next && saw_b_next) winner_next = 2'b11;
        else if (saw_a_next)          winner_next = 2'b01;
        else if (saw_b_next)          winner_next = 2'b10;
`else
        if (saw_a_next)               winner_next = 2'b01;
        else if (saw_b_next)          winner_next = 2'b10;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            winner    <= 2'b00;
            win_index <= '0;
            cnt       <= '0;
            saw_a     <= 1'b0;
            saw_b     <= 1'b0;
            hit       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= SCAN;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        saw_a     <= 1'b0;
                        saw_b     <= 1'b0;
                        hit       <= 1'b0;
                        winner    <= 2'b00;
                        win_index <= '0;
                    end
                end
                SCAN: begin
                    if (accept) begin
                        saw_a <= saw_a_next;
                        saw_b <= saw_b_next;
                        cnt   <= cnt + IDX_W'(1);
                        if (!hit && (any_a || any_b)) begin
                            win_index <= cnt;
                            hit       <= 1'b1;
                        end
                        // The final word closes the scan and latches the result in the same edge.
                        if (last_word) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            winner   <= winner_next;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_win_scan_accumulator.sv
// Scoreboard bench for win_scan_accumulator: directed scans push expected results, a done-driven monitor checks them.
module tb_win_scan_accumulator;

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] check_ans;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic [5:0]  win_index;

    typedef struct {
        logic [1:0] w;
        logic [5:0] i;
        int         c;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] words[60];
    int          cyc = 0;
    int          n_compared = 0;
    int          n_mismatch = 0;
    logic        done_q = 1'b0;

    win_scan_accumulator #(.N_CASES(12), .N_WORDS(60), .IDX_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .check_ans (check_ans),
        .busy      (busy),
        .done      (done),
        .winner    (winner),
        .win_index (win_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each done pulse must match the oldest outstanding scan, including the cycle it lands on.
    always @(negedge clk) begin
        if (done) begin
            if (done_q) checkOutput("done_width", 32'd2, 32'd1);
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("winner", 32'(winner), 32'(e.w));
                checkOutput("win_index", 32'(win_index), 32'(e.i));
                checkOutput("done_cycle", 32'(cyc), 32'(e.c));
            end
        end
        done_q = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearWords();
        for (int i = 0; i < 60; i++) words[i] = 24'h000000;
    endtask

    task automatic applyStimulus(input bit toggle, input bit mid_start, input bit start_in_done,
                                 input int abort_at, input logic [1:0] exp_w, input logic [5:0] exp_i);
        int   p;
        int   w;
        int   k;
        exp_t e;
        p = cyc;
        start = 1'b1;
        if (abort_at < 0) begin
            e.w = exp_w;
            e.i = exp_i;
            e.c = p + 2 + (toggle ? 118 : 59);
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
        checkOutput("scan_busy", 32'(busy), 32'd1);
        checkOutput("scan_ready", 32'(in_ready), 32'd1);
        checkOutput("start_clr_winner", 32'(winner), 32'd0);
        checkOutput("start_clr_index", 32'(win_index), 32'd0);
        w = 0;
        k = 0;
        while (w < 60) begin
            if (abort_at >= 0 && w == abort_at) begin
                reset    = 1'b1;
                in_valid = 1'b0;
                tick();
                reset = 1'b0;
                checkOutput("abort_done", 32'(done), 32'd0);
                checkOutput("abort_busy", 32'(busy), 32'd0);
                checkOutput("abort_ready", 32'(in_ready), 32'd0);
                checkOutput("abort_winner", 32'(winner), 32'd0);
                checkOutput("abort_index", 32'(win_index), 32'd0);
                return;
            end
            in_valid  = toggle ? (k % 2 == 0) : 1'b1;
            check_ans = in_valid ? words[w] : 24'h555555;
            start     = mid_start && (w == 20);
            tick();
            start = 1'b0;
            if (in_valid) w++;
            k++;
        end
        in_valid  = 1'b0;
        check_ans = 24'h000000;
        start     = start_in_done;
        tick();
        start = 1'b0;
        for (int t = 0; t < 8 && sb.size() != 0; t++) tick();
        if (sb.size() != 0) begin
            n_compared++;
            n_mismatch++;
            $display("[TB] FAIL done_timeout: %0d scans pending, expected 0", sb.size());
            sb.delete();
        end
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        check_ans = 24'h000000;
        repeat (2) tick();
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_winner", 32'(winner), 32'd0);
        checkOutput("rst_index", 32'(win_index), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] all-zero scan");
        clearWords();
        applyStimulus(1'b0, 1'b0, 1'b0, -1, 2'b00, 6'd0);

        $display("[TB] colour A at word 17");
        clearWords();
        words[17] = 24'h000040;
        applyStimulus(1'b0, 1'b0, 1'b0, -1, 2'b01, 6'd17);
        repeat (3) tick();
        checkOutput("hold_winner", 32'(winner), 32'd1);
        checkOutput("hold_index", 32'(win_index), 32'd17);

        $display("[TB] colour B at word 5, colour A at word 40");
        clearWords();
        words[5]  = 24'h002000;
        words[40] = 24'h400000;
`ifdef WIN_TIE_DETECT_EN
        applyStimulus(1'b0, 1'b0, 1'b0, -1, 2'b11, 6'd5);
`else
        applyStimulus(1'b0, 1'b0, 1'b0, -1, 2'b01, 6'd5);
`endif

        $display("[TB] invalid fields with toggling valid, colour B at word 59");
        for (int i = 0; i < 60; i++) words[i] = 24'hFFFFFF;
        words[59] = 24'hFFFFFE;
        applyStimulus(1'b1, 1'b0, 1'b0, -1, 2'b10, 6'd59);

        $display("[TB] reset after 30 words");
        clearWords();
        words[3] = 24'h000001;
        applyStimulus(1'b0, 1'b0, 1'b0, 30, 2'b00, 6'd0);
        repeat (2) tick();

        $display("[TB] clean scan with start at word 20 and in the done cycle");
        clearWords();
        words[44] = 24'h008000;
        applyStimulus(1'b0, 1'b1, 1'b1, -1, 2'b10, 6'd44);
        repeat (3) tick();
        checkOutput("final_busy", 32'(busy), 32'd0);
        checkOutput("final_pending", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
